fifo_rd_stream: RTL

//  Read-side engine for the 16x8 synchronous FIFO. Pops words via empty/rd_en/dout and re-emits

---
 rtl/fifo_rd_stream_if.sv | 33 +++
 rtl/fifo_rd_stream.sv | 107 ++++++++++
 2 files changed

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO read port plus valid/ready output stream.
// master = read engine, slave = FIFO + downstream consumer side.
interface fifo_rd_stream_if #(
    parameter int DW = 8
);
    logic          en;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;

    modport master (
        input  en,
        input  fifo_empty,
        input  fifo_dout,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output en,
        output fifo_empty,
        output fifo_dout,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops a 1-cycle-latency FIFO into a 2-entry buffer
// and re-emits words on valid/ready. Optional stats: FIFO_RD_STATS_EN.
module fifo_rd_stream #(
    parameter int DW   = 8,
    parameter int SKID = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_rd_stream_if.master io
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [15:0]      word_cnt,
    output logic             ovf_err
`endif
);

    localparam logic [1:0] FULL = 2'(SKID);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e          state;
    occ_e          state_nx;
    logic          inflight;
    logic          pop;
    logic [1:0]    fill;
    logic [DW-1:0] head;
    logic [DW-1:0] tail;

    assign pop  = io.m_valid & io.m_ready;
    assign fill = 2'(state) + {1'b0, inflight};

    // Issue a read only if the buffer can absorb it when it lands.
    assign io.fifo_rd_en = io.en & ~io.fifo_empty & rst_n
                         & ((fill < FULL) | pop);
    assign io.m_valid    = (state != EMPTY);
    assign io.m_data     = head;

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nx;
    end

    // Occupancy next state: capture adds a word, pop removes one.
    always_comb begin
        state_nx = state;
        unique case (state)
            EMPTY: if (inflight) state_nx = ONE;
            ONE: begin
                if (inflight && !pop)      state_nx = TWO;
                else if (!inflight && pop) state_nx = EMPTY;
            end
            TWO:     if (!inflight && pop) state_nx = ONE;
            default: state_nx = EMPTY;
        endcase
    end

    // Tracks the read issued last cycle whose data lands now.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inflight <= 1'b0;
        else        inflight <= io.fifo_rd_en;
    end

    // Buffer data path: head is the output word, tail the second slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            unique case (state)
                EMPTY: if (inflight) head <= io.fifo_dout;
                ONE: begin
                    if (inflight) begin
                        if (pop) head <= io.fifo_dout;
                        else     tail <= io.fifo_dout;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head <= tail;
                        if (inflight) tail <= io.fifo_dout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FIFO_RD_STATS_EN
    // Completed output transfers, free-running with wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   word_cnt <= 16'd0;
        else if (pop) word_cnt <= word_cnt + 16'd1;
    end

    // Sticky flag: a word landed while both slots were occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         ovf_err <= 1'b0;
        else if (inflight && state == TWO) ovf_err <= 1'b1;
    end
`endif

endmodule
